// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg -- shared definitions for the multi-cycle main controller.
//   * state encoding of the controller FSM
//   * opcode / funct values of the supported MIPS subset
//   * encodings of the npc_sel, reg_dst, wd_sel and alu_op datapath selects
//   * iclass_t: one-hot instruction class produced by mc_decode
// S_TRAP is only reachable when MC_CTRL_TRAP_EN is defined.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  // Next-PC source
  localparam logic [1:0] NPC_PC4    = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_RS     = 2'd3;

  // Register-file destination
  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  // Register-file write data source
  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  // ALU operation
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_LUI = 3'd3;

  // One-hot instruction class; exactly one bit is set for any op/funct.
  typedef struct packed {
    logic rtype_alu;
    logic jr;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic unknown;
  } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// mc_decode -- combinational instruction classifier.
// Ports:
//   op    in  [5:0]  IR[31:26]
//   funct in  [5:0]  IR[5:0] (only meaningful for op 000000)
//   cls   out        one-hot instruction class (iclass_t)
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output iclass_t    cls
);

  always_comb begin
    cls = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU, FN_SUBU: cls.rtype_alu = 1'b1;
          FN_JR:            cls.jr        = 1'b1;
          default:          cls.unknown   = 1'b1;
        endcase
      end
      OP_ORI:  cls.ori     = 1'b1;
      OP_LUI:  cls.lui     = 1'b1;
      OP_LW:   cls.lw      = 1'b1;
      OP_SW:   cls.sw      = 1'b1;
      OP_BEQ:  cls.beq     = 1'b1;
      OP_J:    cls.j       = 1'b1;
      OP_JAL:  cls.jal     = 1'b1;
      default: cls.unknown = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl -- multi-cycle main controller for the MIPS-subset CPU.
// Sequences FETCH -> DECODE -> EXEC -> MEM -> WB over a shared datapath and a
// single ready-handshaked memory port. Holds only the state register; all
// outputs are combinational from state + op/funct/zero/mem_ready and are
// forced to 0 while rst_n is low.
// Optional feature: define MC_CTRL_TRAP_EN to send unrecognised instructions
// to a TRAP state (illegal=1 until reset); otherwise they retire as NOPs.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   op, funct             IR opcode / function fields
//   zero                  ALU equality flag for beq
//   mem_ready             memory completes the current request
//   mem_req, mem_we, iord memory request, write, address select (1 = ALU)
//   ir_we, pc_we, npc_sel IR load, PC load and next-PC source
//   reg_we, reg_dst, wd_sel register-file write controls
//   alu_op, alu_src_b, ext_op ALU / immediate-extender controls
//   retire                last cycle of an instruction
//   illegal               trap indicator
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] npc_sel,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic [2:0] alu_op,
  output logic       alu_src_b,
  output logic       ext_op,
  output logic       retire,
  output logic       illegal
);

  state_t  state_reg;
  state_t  state_next;
  iclass_t cls;

  mc_decode u_decode (
    .op    (op),
    .funct (funct),
    .cls   (cls)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    npc_sel    = NPC_PC4;
    reg_we     = 1'b0;
    reg_dst    = DST_RT;
    wd_sel     = WD_ALU;
    alu_op     = ALU_ADD;
    alu_src_b  = 1'b0;
    ext_op     = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;

    // Outputs are gated by rst_n so nothing (not even mem_req) leaks out
    // while reset is held, even though the state register is already FETCH.
    if (rst_n) begin
      case (state_reg)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we      = 1'b1;
            pc_we      = 1'b1;
            npc_sel    = NPC_PC4;
            state_next = S_DECODE;
          end
        end

        S_DECODE: begin
          if (cls.j || cls.jal) begin
            pc_we      = 1'b1;
            npc_sel    = NPC_JUMP;
            retire     = 1'b1;
            state_next = S_FETCH;
            // PC was already advanced in FETCH, so it holds the link value.
            if (cls.jal) begin
              reg_we  = 1'b1;
              reg_dst = DST_RA;
              wd_sel  = WD_PC;
            end
          end else if (cls.jr) begin
            pc_we      = 1'b1;
            npc_sel    = NPC_RS;
            retire     = 1'b1;
            state_next = S_FETCH;
          end else if (cls.unknown) begin
`ifdef MC_CTRL_TRAP_EN
            state_next = S_TRAP;
`else
            retire     = 1'b1;
            state_next = S_FETCH;
`endif
          end else begin
            state_next = S_EXEC;
          end
        end

        S_EXEC: begin
          if (cls.rtype_alu) begin
            alu_op    = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
            alu_src_b = 1'b0;
          end else if (cls.ori) begin
            alu_op    = ALU_OR;
            alu_src_b = 1'b1;
            ext_op    = 1'b0;
          end else if (cls.lui) begin
            alu_op    = ALU_LUI;
            alu_src_b = 1'b1;
          end else if (cls.lw || cls.sw) begin
            alu_op    = ALU_ADD;
            alu_src_b = 1'b1;
            ext_op    = 1'b1;
          end else if (cls.beq) begin
            alu_op    = ALU_SUB;
            alu_src_b = 1'b0;
          end

          if (cls.beq) begin
            pc_we      = zero;
            npc_sel    = NPC_BRANCH;
            retire     = 1'b1;
            state_next = S_FETCH;
          end else if (cls.lw || cls.sw) begin
            state_next = S_MEM;
          end else begin
            state_next = S_WB;
          end
        end

        S_MEM: begin
          // Request, direction and address select stay constant until ready.
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = cls.sw;
          if (mem_ready) begin
            if (cls.sw) begin
              retire     = 1'b1;
              state_next = S_FETCH;
            end else begin
              state_next = S_WB;
            end
          end
        end

        S_WB: begin
          reg_we     = 1'b1;
          reg_dst    = cls.rtype_alu ? DST_RD : DST_RT;
          wd_sel     = cls.lw ? WD_MEM : WD_ALU;
          retire     = 1'b1;
          state_next = S_FETCH;
        end

`ifdef MC_CTRL_TRAP_EN
        // Sticky: only rst_n leaves this state.
        S_TRAP: begin
          illegal = 1'b1;
        end
`endif

        default: begin
          state_next = S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl -- scoreboard bench for mc_ctrl.
// A reference model expands each instruction (class, wait states, zero flag)
// into the per-cycle output pattern implied by the controller's rules; each
// expected cycle is queued as the stimulus is driven, and an independent
// monitor pops and compares on the falling edge.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, iord, ir_we, pc_we, reg_we;
  logic [1:0] npc_sel, reg_dst, wd_sel;
  logic [2:0] alu_op;
  logic       alu_src_b, ext_op, retire, illegal;

  mc_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .funct     (funct),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .iord      (iord),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .npc_sel   (npc_sel),
    .reg_we    (reg_we),
    .reg_dst   (reg_dst),
    .wd_sel    (wd_sel),
    .alu_op    (alu_op),
    .alu_src_b (alu_src_b),
    .ext_op    (ext_op),
    .retire    (retire),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] npc_sel;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic [2:0] alu_op;
    logic       alu_src_b;
    logic       ext_op;
    logic       retire;
    logic       illegal;
  } out_t;

  typedef struct {
    out_t  v;
    string tag;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       rdy;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    out_t       ev;
    string      tag;
  } step_t;

  typedef enum {K_ADDU, K_SUBU, K_JR, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_BAD} kind_t;

  exp_t  expq[$];
  step_t plan[$];
  int    vectors = 0;
  int    miscompares = 0;

  function automatic kind_t kind_of(input logic [5:0] o, input logic [5:0] f);
    kind_t k;
    case (o)
      6'h00: begin
        case (f)
          6'h21:   k = K_ADDU;
          6'h23:   k = K_SUBU;
          6'h08:   k = K_JR;
          default: k = K_BAD;
        endcase
      end
      6'h0D:   k = K_ORI;
      6'h0F:   k = K_LUI;
      6'h23:   k = K_LW;
      6'h2B:   k = K_SW;
      6'h04:   k = K_BEQ;
      6'h02:   k = K_J;
      6'h03:   k = K_JAL;
      default: k = K_BAD;
    endcase
    return k;
  endfunction

  task automatic add(input logic rdy, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input out_t e, input string t);
    step_t s;
    s.rst = 1'b1; s.rdy = rdy; s.op = o; s.funct = f; s.zero = z; s.ev = e; s.tag = t;
    plan.push_back(s);
  endtask

  task automatic plan_reset(input int n);
    step_t s;
    for (int i = 0; i < n; i++) begin
      s.rst = 1'b0; s.rdy = 1'($urandom); s.op = 6'($urandom); s.funct = 6'($urandom);
      s.zero = 1'($urandom); s.ev = '0; s.tag = "reset";
      plan.push_back(s);
    end
  endtask

  // Expand one instruction into its expected cycle sequence. Memory-idle
  // cycles get a random mem_ready, which the controller must ignore.
  task automatic plan_instr(input logic [5:0] o, input logic [5:0] f,
                            input int wf, input int wm, input logic zb);
    kind_t k;
    out_t  e;
    k = kind_of(o, f);
    for (int i = 0; i < wf; i++) begin
      e = '0; e.mem_req = 1'b1;
      add(1'b0, 6'($urandom), 6'($urandom), 1'($urandom), e, "fetch_wait");
    end
    e = '0; e.mem_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1; e.npc_sel = 2'd0;
    add(1'b1, 6'($urandom), 6'($urandom), 1'($urandom), e, "fetch");

    e = '0;
    if (k == K_J || k == K_JAL || k == K_JR) begin
      e.pc_we = 1'b1; e.npc_sel = (k == K_JR) ? 2'd3 : 2'd2; e.retire = 1'b1;
      if (k == K_JAL) begin e.reg_we = 1'b1; e.reg_dst = 2'd2; e.wd_sel = 2'd2; end
      add(1'($urandom), o, f, 1'($urandom), e, "decode_jump");
      return;
    end
    if (k == K_BAD) begin
`ifdef MC_CTRL_TRAP_EN
      add(1'($urandom), o, f, 1'($urandom), e, "decode_bad");
      for (int i = 0; i < 4; i++) begin
        e = '0; e.illegal = 1'b1;
        add(1'($urandom), o, f, 1'($urandom), e, "trap");
      end
`else
      e.retire = 1'b1;
      add(1'($urandom), o, f, 1'($urandom), e, "decode_nop");
`endif
      return;
    end
    add(1'($urandom), o, f, 1'($urandom), e, "decode");

    e = '0;
    case (k)
      K_ADDU: begin e.alu_op = 3'd0; e.alu_src_b = 1'b0; end
      K_SUBU: begin e.alu_op = 3'd1; e.alu_src_b = 1'b0; end
      K_ORI:  begin e.alu_op = 3'd2; e.alu_src_b = 1'b1; e.ext_op = 1'b0; end
      K_LUI:  begin e.alu_op = 3'd3; e.alu_src_b = 1'b1; end
      K_LW, K_SW: begin e.alu_op = 3'd0; e.alu_src_b = 1'b1; e.ext_op = 1'b1; end
      K_BEQ:  begin e.alu_op = 3'd1; e.alu_src_b = 1'b0; e.pc_we = zb; e.npc_sel = 2'd1; e.retire = 1'b1; end
      default: ;
    endcase
    add(1'($urandom), o, f, (k == K_BEQ) ? zb : 1'($urandom), e, "exec");
    if (k == K_BEQ) return;

    if (k == K_LW || k == K_SW) begin
      e = '0; e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = (k == K_SW);
      for (int i = 0; i < wm; i++) add(1'b0, o, f, 1'($urandom), e, "mem_wait");
      e.retire = (k == K_SW);
      add(1'b1, o, f, 1'($urandom), e, "mem");
      if (k == K_SW) return;
    end

    e = '0; e.reg_we = 1'b1; e.retire = 1'b1;
    e.reg_dst = (k == K_ADDU || k == K_SUBU) ? 2'd1 : 2'd0;
    e.wd_sel  = (k == K_LW) ? 2'd1 : 2'd0;
    add(1'($urandom), o, f, 1'($urandom), e, "wb");
  endtask

  // Drive the planned cycles (at most 'limit' when limit >= 0), then drop the rest.
  task automatic drive_plan(input int limit);
    int n;
    n = (limit < 0 || limit > plan.size()) ? plan.size() : limit;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst_n = plan[i].rst; mem_ready = plan[i].rdy; op = plan[i].op;
      funct = plan[i].funct; zero = plan[i].zero;
      expq.push_back('{plan[i].ev, plan[i].tag});
    end
    plan.delete();
  endtask

  task automatic run(input logic [5:0] o, input logic [5:0] f, input int wf, input int wm, input logic zb);
    plan_instr(o, f, wf, wm, zb);
    drive_plan(-1);
  endtask

  always @(negedge clk) begin : monitor
    out_t act;
    exp_t e;
    act = {mem_req, mem_we, iord, ir_we, pc_we, npc_sel, reg_we, reg_dst, wd_sel,
           alu_op, alu_src_b, ext_op, retire, illegal};
    if (expq.size() > 0) begin
      e = expq.pop_front();
      vectors++;
      if (act !== e.v) begin
        miscompares++;
        $display("FAIL %s @%0t: outputs %h, expected %h", e.tag, $time, act, e.v);
      end else begin
        $display("ok   %s @%0t: outputs %h", e.tag, $time, act);
      end
    end
  end

  logic [5:0] tbl_op [10] = '{6'h00, 6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03};
  logic [5:0] tbl_fn [10] = '{6'h21, 6'h23, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

  initial begin
    logic [5:0] ro, rf;
    int idx;

    // Reset held, then first instruction fetched in the very first free cycle.
    plan_reset(3);
    drive_plan(-1);
    run(6'h00, 6'h21, 0, 0, 1'b0);        // addu, 4 cycles
    run(6'h23, 6'h00, 0, 3, 1'b0);        // lw, 3 MEM waits, 8 cycles
    run(6'h04, 6'h00, 0, 0, 1'b1);        // beq taken
    run(6'h04, 6'h00, 0, 0, 1'b0);        // beq not taken
    run(6'h03, 6'h00, 0, 0, 1'b0);        // jal
    run(6'h00, 6'h08, 0, 0, 1'b0);        // jr
    run(6'h00, 6'h23, 2, 0, 1'b0);        // subu with fetch waits
    run(6'h0D, 6'h15, 0, 0, 1'b0);        // ori
    run(6'h0F, 6'h3A, 1, 0, 1'b0);        // lui
    run(6'h2B, 6'h00, 0, 2, 1'b0);        // sw
    run(6'h02, 6'h00, 0, 0, 1'b0);        // j

    // Reset in the middle of a waiting MEM access abandons the request.
    plan_instr(6'h23, 6'h00, 0, 5, 1'b0);
    drive_plan(5);
    plan_reset(2);
    drive_plan(-1);
    run(6'h0D, 6'h00, 0, 0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      idx = $urandom_range(0, 9);
      ro = tbl_op[idx];
      rf = (ro == 6'h00) ? tbl_fn[idx] : 6'($urandom);
`ifndef MC_CTRL_TRAP_EN
      if ($urandom_range(0, 9) == 0) begin
        ro = 6'h00; rf = 6'h20;           // unsupported R-type funct
      end
`endif
      run(ro, rf, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
    end

    // Unrecognised opcode: trap (until reset) or NOP depending on the build.
    run(6'h3F, 6'h00, 0, 0, 1'b0);
    plan_reset(2);
    drive_plan(-1);
    run(6'h00, 6'h21, 0, 0, 1'b0);

    @(negedge clk); #1;
    vectors++;
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected cycles left, required 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
